// File: rtl/alu_pkg.sv
// Shared types for the ALU requester: operands, results, opcodes, command word, FSM states.
// Latency: n/a (types only).
// Backpressure: n/a.
package alu_pkg;

    typedef logic [7:0]  operand_t;
    typedef logic [15:0] result_t;

    typedef enum logic [2:0] {
        NOP = 3'd0,
        ADD = 3'd1,
        SUB = 3'd2,
        NOT = 3'd3,
        XOR = 3'd4,
        AND = 3'd5,
        MUL = 3'd6,
        INC = 3'd7
    } opcode_t;

    typedef struct packed {
        operand_t a;
        operand_t b;
        opcode_t  op;
    } alu_cmd_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_RESP  = 3'd3,
        ST_GAP   = 3'd4
    } req_state_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// Command FIFO holding alu_cmd_t words; head is visible combinationally on pop_dat_o.
// Latency: a pushed word is at the head the cycle after the push edge.
// Backpressure: push ignored when full, pop ignored when empty.
module alu_cmd_fifo
    import alu_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       push_i,
    input  alu_cmd_t                   push_dat_i,
    input  logic                       pop_i,
    output alu_cmd_t                   pop_dat_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH):0]     count_o
);

    localparam int AW = $clog2(DEPTH);

    alu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q;
    logic [AW-1:0]   rd_ptr_q;
    logic [AW:0]     count_q;
    logic            do_push;
    logic            do_pop;

    assign full_o    = (count_q == (AW+1)'(DEPTH));
    assign empty_o   = (count_q == '0);
    assign count_o   = count_q;
    assign pop_dat_o = mem_q[rd_ptr_q];
    assign do_push   = push_i && !full_o;
    assign do_pop    = pop_i && !empty_o;

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_dat_i;
    end

endmodule

// File: rtl/alu_requester.sv
// ALU initiator: queues commands, runs one start/done op at a time, returns result on rsp port.
// Latency: cmd handshake edge N -> alu_start after N+2; 1-cycle ALU -> rsp_valid after N+4.
// Backpressure: cmd_ready drops when FIFO full; response held until rsp_ready.
module alu_requester
    import alu_pkg::*;
#(
    parameter int CMD_DEPTH   = 4,
    parameter int TIMEOUT_CYC = 16,
    parameter int GAP_CYC     = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic [7:0]  cmd_a_i,
    input  logic [7:0]  cmd_b_i,
    input  logic [2:0]  cmd_op_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [15:0] rsp_result_o,
    output logic [2:0]  rsp_op_o,
    output logic        rsp_err_o,
    output logic [7:0]  alu_a_o,
    output logic [7:0]  alu_b_o,
    output logic [2:0]  alu_opcode_o,
    output logic        alu_start_o,
    input  logic [15:0] alu_result_i,
    input  logic        alu_done_i,
    output logic        busy_o,
    output logic [15:0] op_count_o
);

    localparam int TW = $clog2(TIMEOUT_CYC);
    localparam int GW = (GAP_CYC > 1) ? $clog2(GAP_CYC) : 1;
    localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [GW-1:0] GAP_LAST = GW'(GAP_CYC - 1);

    req_state_t  state_q;
    alu_cmd_t    op_q;
    logic        start_q;
    logic [TW-1:0] tmo_q;
    logic [GW-1:0] gap_q;
    logic        rsp_valid_q;
    result_t     rsp_result_q;
    opcode_t     rsp_op_q;
    logic        rsp_err_q;
    logic [15:0] op_count_q;

    alu_cmd_t    fifo_head;
    alu_cmd_t    fifo_in;
    logic        fifo_full;
    logic        fifo_empty;
    logic        fifo_push;
    logic        fifo_pop;
    logic [$clog2(CMD_DEPTH):0] fifo_count;

    assign cmd_ready_o = reset_n && !fifo_full;
    assign fifo_push   = cmd_valid_i && cmd_ready_o;
    assign fifo_pop    = (state_q == ST_IDLE) && !fifo_empty;
    assign fifo_in     = alu_cmd_t'({cmd_a_i, cmd_b_i, cmd_op_i});

    alu_cmd_fifo #(.DEPTH(CMD_DEPTH)) u_fifo (
        .clk        (clk),
        .reset_n    (reset_n),
        .push_i     (fifo_push),
        .push_dat_i (fifo_in),
        .pop_i      (fifo_pop),
        .pop_dat_o  (fifo_head),
        .full_o     (fifo_full),
        .empty_o    (fifo_empty),
        .count_o    (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            op_q         <= '{a: '0, b: '0, op: NOP};
            start_q      <= 1'b0;
            tmo_q        <= '0;
            gap_q        <= '0;
            rsp_valid_q  <= 1'b0;
            rsp_result_q <= '0;
            rsp_op_q     <= NOP;
            rsp_err_q    <= 1'b0;
            op_count_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        op_q    <= fifo_head;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    start_q <= 1'b1;
                    tmo_q   <= '0;
                    state_q <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (alu_done_i) begin
                        start_q      <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= (op_q.op == NOP) ? '0 : alu_result_i;
                        rsp_op_q     <= op_q.op;
                        rsp_err_q    <= 1'b0;
                        state_q      <= ST_RESP;
                    end else if (tmo_q == TMO_LAST) begin
                        // ALU never answered: abort with an error response.
                        start_q      <= 1'b0;
                        rsp_valid_q  <= 1'b1;
                        rsp_result_q <= '0;
                        rsp_op_q     <= op_q.op;
                        rsp_err_q    <= 1'b1;
                        state_q      <= ST_RESP;
                    end else begin
                        tmo_q <= tmo_q + TW'(1);
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i) begin
                        rsp_valid_q <= 1'b0;
                        if (op_count_q != 16'hFFFF) op_count_q <= op_count_q + 16'd1;
                        gap_q   <= '0;
                        state_q <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    // ALU needs start low for a while to drop done.
                    if (gap_q == GAP_LAST) state_q <= ST_IDLE;
                    else                   gap_q   <= gap_q + GW'(1);
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign alu_a_o      = op_q.a;
    assign alu_b_o      = op_q.b;
    assign alu_opcode_o = op_q.op;
    assign alu_start_o  = start_q;
    assign rsp_valid_o  = rsp_valid_q;
    assign rsp_result_o = rsp_result_q;
    assign rsp_op_o     = rsp_op_q;
    assign rsp_err_o    = rsp_err_q;
    assign op_count_o   = op_count_q;
    assign busy_o       = (fifo_count != '0) || (state_q != ST_IDLE);

endmodule

// File: tb/tb_alu_requester.sv
// Bench for alu_requester: behavioural ALU, transaction-level response model, directed + random traffic.
module tb_alu_requester;
    import alu_pkg::*;

    localparam int TMO = 16;
    localparam int GAP = 1;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cmd_valid_i = 1'b0;
    logic        cmd_ready_o;
    logic [7:0]  cmd_a_i = '0;
    logic [7:0]  cmd_b_i = '0;
    logic [2:0]  cmd_op_i = '0;
    logic        rsp_valid_o;
    logic        rsp_ready_i = 1'b0;
    logic [15:0] rsp_result_o;
    logic [2:0]  rsp_op_o;
    logic        rsp_err_o;
    logic [7:0]  alu_a_o;
    logic [7:0]  alu_b_o;
    logic [2:0]  alu_opcode_o;
    logic        alu_start_o;
    logic [15:0] alu_result_i = '0;
    logic        alu_done_i = 1'b0;
    logic        busy_o;
    logic [15:0] op_count_o;

    always #5 clk = ~clk;

    alu_requester #(.CMD_DEPTH(4), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
        .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i), .cmd_op_i(cmd_op_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_result_o(rsp_result_o), .rsp_op_o(rsp_op_o), .rsp_err_o(rsp_err_o),
        .alu_a_o(alu_a_o), .alu_b_o(alu_b_o), .alu_opcode_o(alu_opcode_o),
        .alu_start_o(alu_start_o), .alu_result_i(alu_result_i), .alu_done_i(alu_done_i),
        .busy_o(busy_o), .op_count_o(op_count_o)
    );

    int n_cmp = 0;
    int n_fail = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ALU behaviour: NOP returns junk that the requester must zero; A=B=EE never finishes.
    function automatic logic [15:0] alu_fn(input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
        case (opcode_t'(op))
            NOP:     return 16'hDEAD;
            ADD:     return {8'h00, a} + {8'h00, b};
            SUB:     return {8'h00, a - b};
            NOT:     return {8'h00, ~a};
            XOR:     return {8'h00, a ^ b};
            AND:     return {8'h00, a & b};
            MUL:     return {8'h00, a} * {8'h00, b};
            default: return {8'h00, a} + 16'd1;
        endcase
    endfunction

    function automatic int alu_lat(input logic [2:0] op);
        if (op == MUL) return 3;
        if (op == INC) return 2;
        return 1;
    endfunction

    int alu_cnt = 0;
    always @(posedge clk) begin
        if (!alu_start_o) begin
            alu_done_i <= 1'b0;
            alu_cnt = 0;
        end else if (!alu_done_i && !(alu_a_o == 8'hEE && alu_b_o == 8'hEE)) begin
            alu_cnt = alu_cnt + 1;
            if (alu_cnt >= alu_lat(alu_opcode_o)) begin
                alu_done_i   <= 1'b1;
                alu_result_i <= alu_fn(alu_opcode_o, alu_a_o, alu_b_o);
            end
        end
    end

    typedef struct packed {
        logic [15:0] res;
        logic [2:0]  op;
        logic        err;
    } exp_t;

    exp_t expq[$];
    int   mdl_cnt = 0;

    function automatic exp_t predict(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
        exp_t e;
        e.op  = op;
        e.err = (a == 8'hEE && b == 8'hEE);
        e.res = (e.err || op == NOP) ? 16'h0000 : alu_fn(op, a, b);
        return e;
    endfunction

    logic rr_rand = 1'b0;
    logic rr_fixed = 1'b1;
    always @(negedge clk) rsp_ready_i = rr_rand ? ($urandom_range(0, 3) != 0) : rr_fixed;

    // Compare process: response stream against model queue, op_count, ALU-side protocol.
    logic       prev_start = 1'b0;
    logic [7:0] prev_a = '0, prev_b = '0;
    logic [2:0] prev_op = '0;
    int         low_run = 1000;
    int         high_run = 0;
    always @(negedge clk) begin
        #1;
        if (!reset_n) begin
            prev_start = 1'b0;
            low_run    = 1000;
            high_run   = 0;
        end else begin
            chk("op_count", op_count_o, mdl_cnt);
            if (rsp_valid_o) begin
                if (expq.size() == 0) chk("rsp_unexpected", 1, 0);
                else begin
                    chk("rsp_result", rsp_result_o, expq[0].res);
                    chk("rsp_op", rsp_op_o, expq[0].op);
                    chk("rsp_err", rsp_err_o, expq[0].err);
                    if (rsp_ready_i) begin
                        void'(expq.pop_front());
                        if (mdl_cnt < 65535) mdl_cnt++;
                    end
                end
            end
            if (alu_start_o) begin
                if (!prev_start) begin
                    chk("start_gap_ok", (low_run >= GAP) ? 1 : 0, 1);
                    high_run = 0;
                end else begin
                    chk("alu_a_stable", alu_a_o, prev_a);
                    chk("alu_b_stable", alu_b_o, prev_b);
                    chk("alu_op_stable", alu_opcode_o, prev_op);
                end
                high_run++;
                prev_a  = alu_a_o;
                prev_b  = alu_b_o;
                prev_op = alu_opcode_o;
            end else begin
                if (prev_start) begin
                    chk("start_hi_bound", (high_run <= TMO) ? 1 : 0, 1);
                    if (prev_a == 8'hEE && prev_b == 8'hEE) chk("timeout_len", high_run, TMO);
                    low_run = 0;
                end
                low_run++;
            end
            prev_start = alu_start_o;
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] a, input logic [7:0] b, input logic [2:0] op, output int acc);
        logic rdy;
        int   tries = 0;
        cmd_valid_i = 1'b1;
        cmd_a_i = a;
        cmd_b_i = b;
        cmd_op_i = op;
        acc = -1;
        forever begin
            rdy = cmd_ready_o;
            tick();
            if (rdy) begin
                expq.push_back(predict(a, b, op));
                acc = cyc;
                break;
            end
            tries++;
            if (tries > 300) begin
                chk("send_timeout", 0, 1);
                break;
            end
        end
    endtask

    task automatic wait_rsp(output logic [15:0] res, output logic [2:0] op, output logic err, output int c);
        int n = 0;
        res = '0; op = '0; err = 1'b0; c = -1;
        while (!rsp_valid_o && n < 300) begin
            tick();
            n++;
        end
        if (!rsp_valid_o) chk("wait_rsp_timeout", 0, 1);
        else begin
            res = rsp_result_o;
            op  = rsp_op_o;
            err = rsp_err_o;
            c   = cyc;
            tick();
        end
    endtask

    task automatic wait_start(output int c);
        int n = 0;
        c = -1;
        while (!alu_start_o && n < 300) begin
            tick();
            n++;
        end
        if (!alu_start_o) chk("wait_start_timeout", 0, 1);
        else c = cyc;
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        cmd_valid_i = 1'b0;
        expq.delete();
        mdl_cnt = 0;
        tick();
        chk("rst_cmd_ready", cmd_ready_o, 0);
        chk("rst_rsp_valid", rsp_valid_o, 0);
        chk("rst_rsp_result", rsp_result_o, 0);
        chk("rst_rsp_op", rsp_op_o, NOP);
        chk("rst_rsp_err", rsp_err_o, 0);
        chk("rst_alu_start", alu_start_o, 0);
        chk("rst_alu_a", alu_a_o, 0);
        chk("rst_alu_b", alu_b_o, 0);
        chk("rst_alu_opcode", alu_opcode_o, NOP);
        chk("rst_busy", busy_o, 0);
        chk("rst_op_count", op_count_o, 0);
        tick();
        reset_n = 1'b1;
        tick();
        chk("post_rst_cmd_ready", cmd_ready_o, 1);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, c, c2, nrsp;
        logic [15:0] r;
        logic [2:0]  o;
        logic        e;
        logic [7:0]  ra, rb;
        logic [2:0]  rop;

        @(negedge clk);
        do_reset();

        // 1: ADD latency and result
        rr_fixed = 1'b1;
        send(8'h05, 8'h03, ADD, acc);
        cmd_valid_i = 1'b0;
        wait_start(c);
        chk("t1_start_latency", c - acc, 2);
        wait_rsp(r, o, e, c2);
        chk("t1_rsp_latency", c2 - acc, 4);
        chk("t1_result", r, 16'h0008);
        chk("t1_err", e, 0);

        // 2: MUL with multi-cycle ALU latency
        repeat (3) tick();
        do_reset();
        send(8'hFF, 8'hFF, MUL, acc);
        cmd_valid_i = 1'b0;
        wait_rsp(r, o, e, c2);
        chk("t2_result", r, 16'hFE01);
        chk("t2_op_count", op_count_o, 1);

        // 3: fill the FIFO while the response is held
        repeat (3) tick();
        rr_fixed = 1'b0;
        tick();
        for (int i = 0; i < 5; i++) send(8'(i + 1), 8'(2 * i), ADD, acc);
        cmd_valid_i = 1'b0;
        chk("t3_ready_when_full", cmd_ready_o, 0);
        chk("t3_busy", busy_o, 1);
        rr_fixed = 1'b1;
        nrsp = 0;
        while (expq.size() != 0 && nrsp < 500) begin
            tick();
            nrsp++;
        end
        chk("t3_drained", expq.size(), 0);

        // 4: ALU never answers, then a normal op follows
        repeat (3) tick();
        send(8'hEE, 8'hEE, ADD, acc);
        send(8'h01, 8'h02, ADD, acc);
        cmd_valid_i = 1'b0;
        wait_rsp(r, o, e, c2);
        chk("t4_err", e, 1);
        chk("t4_result", r, 0);
        wait_rsp(r, o, e, c2);
        chk("t4_next_err", e, 0);
        chk("t4_next_result", r, 16'h0003);

        // 5: XOR then NOP
        send(8'hAA, 8'h0F, XOR, acc);
        send(8'h12, 8'h34, NOP, acc);
        cmd_valid_i = 1'b0;
        wait_rsp(r, o, e, c2);
        chk("t5_xor_result", r, 16'h00A5);
        wait_rsp(r, o, e, c2);
        chk("t5_nop_result", r, 0);
        chk("t5_nop_op", o, NOP);

        // 6: reset while waiting on the ALU with two commands queued
        repeat (3) tick();
        send(8'hEE, 8'hEE, SUB, acc);
        send(8'h10, 8'h20, AND, acc);
        send(8'h30, 8'h40, XOR, acc);
        cmd_valid_i = 1'b0;
        wait_start(c);
        repeat (3) tick();
        chk("t6_in_wait", alu_start_o, 1);
        do_reset();
        nrsp = 0;
        for (int i = 0; i < 30; i++) begin
            if (rsp_valid_o) nrsp++;
            tick();
        end
        chk("t6_no_rsp", nrsp, 0);
        chk("t6_idle_busy", busy_o, 0);

        // Random traffic with random response backpressure
        rr_rand = 1'b1;
        for (int i = 0; i < 80; i++) begin
            cmd_valid_i = 1'b0;
            repeat ($urandom_range(0, 3)) tick();
            ra  = 8'($urandom);
            rb  = 8'($urandom);
            rop = 3'($urandom);
            if ($urandom_range(0, 9) == 0) begin
                ra = 8'hEE;
                rb = 8'hEE;
            end else if (ra == 8'hEE && rb == 8'hEE) begin
                rb = 8'h00;
            end
            send(ra, rb, rop, acc);
        end
        cmd_valid_i = 1'b0;
        nrsp = 0;
        while (expq.size() != 0 && nrsp < 5000) begin
            tick();
            nrsp++;
        end
        chk("rand_drained", expq.size(), 0);
        rr_rand = 1'b0;
        repeat (4) tick();
        chk("rand_idle_busy", busy_o, 0);
        chk("rand_op_count", op_count_o, mdl_cnt);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
